// File: rtl/register_arbiter_if.sv
// Requester-side and register_block-side signals of register_arbiter.
// Packed requester vectors carry requester k in slice k.
interface register_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]              i_w_en;
  logic [2*ADDR_WIDTH-1:0] i_w_addr;
  logic [2*DATA_WIDTH-1:0] i_w_value;
  logic [1:0]              i_r_en;
  logic [2*ADDR_WIDTH-1:0] i_r_addr;
  logic [2*DATA_WIDTH-1:0] o_r_value;
  logic [1:0]              o_r_valid;
  logic [1:0]              o_busy;
  logic [1:0]              o_drop;
  logic                    o_timeout;
  logic                    o_w_en;
  logic [ADDR_WIDTH-1:0]   o_w_addr;
  logic [DATA_WIDTH-1:0]   o_w_value;
  logic                    o_r_en;
  logic [ADDR_WIDTH-1:0]   o_r_addr;
  logic [DATA_WIDTH-1:0]   i_r_value;
  logic                    i_r_valid;

  modport slave (
    input  i_w_en, i_w_addr, i_w_value, i_r_en, i_r_addr, i_r_value, i_r_valid,
    output o_r_value, o_r_valid, o_busy, o_drop, o_timeout,
           o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr
  );

  modport master (
    output i_w_en, i_w_addr, i_w_value, i_r_en, i_r_addr, i_r_value, i_r_valid,
    input  o_r_value, o_r_valid, o_busy, o_drop, o_timeout,
           o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr
  );
endinterface

// File: rtl/register_arbiter.sv
// Two-requester round-robin arbiter in front of register_block: one buffered
// operation per requester, grant held through the read-response wait.
module register_arbiter_slot #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] w_value,
  input  logic                  clr,
  output logic                  full,
  output logic                  is_write,
  output logic                  drop,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  always_ff @(posedge clk or negedge i_reset_n)
    if (!i_reset_n) begin
      full     <= 1'b0;
      is_write <= 1'b0;
      drop     <= 1'b0;
      addr     <= '0;
      data     <= '0;
    end else begin
      // A full slot refuses everything, even in the cycle it is being cleared.
      drop <= full ? (w_en | r_en) : (w_en & r_en);
      if (full) begin
        if (clr) full <= 1'b0;
      end else if (w_en | r_en) begin
        full     <= 1'b1;
        is_write <= w_en;
        addr     <= w_en ? w_addr : r_addr;
        data     <= w_en ? w_value : '0;
      end
    end
endmodule

module register_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             i_reset_n,
  register_arbiter_if.slave bus
);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ_ISSUE, READ_WAIT} state_t;

  state_t                     state;
  logic                       g, last, nxt_g, done;
  logic [CW-1:0]              cnt;
  logic [1:0]                 full, is_write, drop, clr, r_valid;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] data, r_value;
  logic                       w_en, r_en, timeout;
  logic [ADDR_WIDTH-1:0]      w_addr, r_addr;
  logic [DATA_WIDTH-1:0]      w_value;

  for (genvar k = 0; k < 2; k++) begin : g_slot
    register_arbiter_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk      (clk),
      .i_reset_n(i_reset_n),
      .w_en     (bus.i_w_en[k]),
      .r_en     (bus.i_r_en[k]),
      .w_addr   (bus.i_w_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .r_addr   (bus.i_r_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .w_value  (bus.i_w_value[k*DATA_WIDTH +: DATA_WIDTH]),
      .clr      (clr[k]),
      .full     (full[k]),
      .is_write (is_write[k]),
      .drop     (drop[k]),
      .addr     (addr[k]),
      .data     (data[k])
    );
    assign clr[k] = done & (g == 1'(k));
  end

  // Tie goes to whoever was not granted last; a lone full slot always wins.
  assign nxt_g = (&full) ? ~last : full[1];
  assign done  = (state == WRITE) ||
                 ((state == READ_WAIT) && (bus.i_r_valid || cnt == CNT_LAST));

  always_ff @(posedge clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state   <= IDLE;
      g       <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      w_en    <= 1'b0;
      w_addr  <= '0;
      w_value <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_valid <= '0;
      r_value <= '0;
      timeout <= 1'b0;
    end else begin
      w_en    <= 1'b0;
      w_addr  <= '0;
      w_value <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_valid <= '0;
      timeout <= 1'b0;
      case (state)
        IDLE:
          if (|full) begin
            g    <= nxt_g;
            last <= nxt_g;
            if (is_write[nxt_g]) begin
              state   <= WRITE;
              w_en    <= 1'b1;
              w_addr  <= addr[nxt_g];
              w_value <= data[nxt_g];
            end else begin
              state  <= READ_ISSUE;
              r_en   <= 1'b1;
              r_addr <= addr[nxt_g];
            end
          end
        WRITE: state <= IDLE;
        READ_ISSUE: begin
          cnt   <= '0;
          state <= READ_WAIT;
        end
        READ_WAIT:
          if (bus.i_r_valid) begin
            r_value[g] <= bus.i_r_value;
            r_valid[g] <= 1'b1;
            state      <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end

  assign bus.o_w_en    = w_en;
  assign bus.o_w_addr  = w_addr;
  assign bus.o_w_value = w_value;
  assign bus.o_r_en    = r_en;
  assign bus.o_r_addr  = r_addr;
  assign bus.o_r_value = r_value;
  assign bus.o_r_valid = r_valid;
  assign bus.o_busy    = full;
  assign bus.o_drop    = drop;
  assign bus.o_timeout = timeout;
endmodule

// File: tb/tb_register_arbiter.sv
// Bench for register_arbiter: directed and random transactions scored against a
// transaction schedule built from the arbitration and latency rules.
module tb_register_arbiter;
  localparam int AW = 8, DW = 32, TIMEOUT = 15, W = 44;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  register_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Memories: ref_mem follows the schedule, blk_mem is what the register_block model holds.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] blk_mem [256];
  logic [DW-1:0] m_rval  [2];
  bit            m_last;
  int            lat_q [$];
  int            rv_cnt;
  logic [DW-1:0] rv_data;

  // Stimulus for one transaction group, presented in cycle 0.
  bit            req [2], wr [2], dup [2], wrrd [2], spur;
  logic [AW-1:0] ad [2];
  logic [DW-1:0] dt [2];
  int            lat [2];

  // Per-cycle expectations.
  logic [W-1:0]  e_w_en, e_r_en, e_to;
  logic [AW-1:0] e_w_addr [W];
  logic [DW-1:0] e_w_value [W];
  logic [AW-1:0] e_r_addr [W];
  logic [1:0]    e_rv [W], e_busy [W], e_drop [W];

  task automatic clear_stim();
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; wr[k] = 0; dup[k] = 0; wrrd[k] = 0;
      ad[k] = '0; dt[k] = '0; lat[k] = 0;
    end
    spur = 0;
  endtask

  task automatic run_iter();
    int s;
    int order [$];
    for (int c = 0; c < W; c++) begin
      e_w_en[c] = 0; e_r_en[c] = 0; e_to[c] = 0;
      e_w_addr[c] = '0; e_w_value[c] = '0; e_r_addr[c] = '0;
      e_rv[c] = '0; e_busy[c] = '0; e_drop[c] = '0;
    end
    lat_q.delete();
    rv_cnt = 0;
    if (req[0] && req[1]) order = m_last ? '{0, 1} : '{1, 0};
    else if (req[0]) order = '{0};
    else if (req[1]) order = '{1};
    // First evaluation in cycle 1; each op's length follows from its kind and latency.
    s = 1;
    foreach (order[i]) begin
      int k;
      k = order[i];
      m_last = k[0];
      if (wrrd[k]) e_drop[1][k] = 1'b1;
      if (dup[k])  e_drop[2][k] = 1'b1;
      if (wr[k]) begin
        e_w_en[s+1] = 1'b1; e_w_addr[s+1] = ad[k]; e_w_value[s+1] = dt[k];
        ref_mem[ad[k]] = dt[k];
        for (int c = 1; c <= s + 1; c++) e_busy[c][k] = 1'b1;
        s += 2;
      end else begin
        e_r_en[s+1] = 1'b1; e_r_addr[s+1] = ad[k];
        lat_q.push_back(lat[k]);
        if (lat[k] < 0) begin
          e_to[s+2+TIMEOUT] = 1'b1;
          for (int c = 1; c <= s + 1 + TIMEOUT; c++) e_busy[c][k] = 1'b1;
          s += 2 + TIMEOUT;
        end else begin
          e_rv[s+3+lat[k]][k] = 1'b1;
          m_rval[k] = ref_mem[ad[k]];
          for (int c = 1; c <= s + 2 + lat[k]; c++) e_busy[c][k] = 1'b1;
          s += 3 + lat[k];
        end
      end
    end

    for (int c = 0; c < W; c++) begin
      @(posedge clk); #1;
      bus.i_w_en = '0; bus.i_r_en = '0; bus.i_r_valid = 1'b0; bus.i_r_value = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (c == 0 && req[k]) begin
          if (wr[k]) begin
            bus.i_w_en[k] = 1'b1;
            bus.i_w_addr[k*AW +: AW]  = ad[k];
            bus.i_w_value[k*DW +: DW] = dt[k];
            if (wrrd[k]) begin
              bus.i_r_en[k] = 1'b1;
              bus.i_r_addr[k*AW +: AW] = ~ad[k];
            end
          end else begin
            bus.i_r_en[k] = 1'b1;
            bus.i_r_addr[k*AW +: AW] = ad[k];
          end
        end
        if (c == 1 && dup[k]) begin
          bus.i_r_en[k] = 1'b1;
          bus.i_r_addr[k*AW +: AW] = AW'($urandom);
        end
      end
      if (c == 0 && spur) bus.i_r_valid = 1'b1;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.i_r_valid = 1'b1;
          bus.i_r_value = rv_data;
        end
      end
      @(negedge clk);
      chk($sformatf("w_en@%0d", c),    bus.o_w_en,    e_w_en[c]);
      chk($sformatf("w_addr@%0d", c),  bus.o_w_addr,  e_w_addr[c]);
      chk($sformatf("w_value@%0d", c), bus.o_w_value, e_w_value[c]);
      chk($sformatf("r_en@%0d", c),    bus.o_r_en,    e_r_en[c]);
      chk($sformatf("r_addr@%0d", c),  bus.o_r_addr,  e_r_addr[c]);
      chk($sformatf("r_valid@%0d", c), bus.o_r_valid, e_rv[c]);
      chk($sformatf("busy@%0d", c),    bus.o_busy,    e_busy[c]);
      chk($sformatf("drop@%0d", c),    bus.o_drop,    e_drop[c]);
      chk($sformatf("timeout@%0d", c), bus.o_timeout, e_to[c]);
      for (int k = 0; k < 2; k++)
        if (e_rv[c][k]) chk($sformatf("r_value%0d@%0d", k, c), bus.o_r_value[k*DW +: DW], m_rval[k]);
      // register_block model: answers L+1 cycles after o_r_en, or never.
      if (bus.o_r_en && lat_q.size() > 0) begin
        int l;
        l = lat_q.pop_front();
        if (l >= 0) begin
          rv_cnt  = l + 1;
          rv_data = blk_mem[bus.o_r_addr];
        end
      end
      if (bus.o_w_en) blk_mem[bus.o_w_addr] = bus.o_w_value;
    end
    chk("r_value0_hold", bus.o_r_value[DW-1:0],  m_rval[0]);
    chk("r_value1_hold", bus.o_r_value[2*DW-1:DW], m_rval[1]);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_w_en = '0; bus.i_w_addr = '0; bus.i_w_value = '0;
    bus.i_r_en = '0; bus.i_r_addr = '0; bus.i_r_value = '0; bus.i_r_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'(i) * 32'h0100_0193;
      blk_mem[i] = ref_mem[i];
    end
    m_rval[0] = '0; m_rval[1] = '0; m_last = 1'b1;
    rv_cnt = 0; rv_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  bus.o_busy, 2'b00);
    chk("rst_bus",   {bus.o_w_en, bus.o_r_en, bus.o_w_addr, bus.o_r_addr}, '0);
    chk("rst_flags", {bus.o_r_valid, bus.o_drop, bus.o_timeout}, '0);
    chk("rst_rval",  bus.o_r_value, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single write from requester 0.
    clear_stim(); req[0] = 1; wr[0] = 1; ad[0] = 8'h03; dt[0] = 32'hDEAD_BEEF; run_iter();
    // Single read from requester 1, answered one cycle after o_r_en.
    ref_mem[5] = 32'h1234_5678; blk_mem[5] = 32'h1234_5678;
    clear_stim(); req[1] = 1; ad[1] = 8'h05; lat[1] = 0; run_iter();
    // Contention, twice.
    for (int i = 0; i < 2; i++) begin
      clear_stim();
      req[0] = 1; wr[0] = 1; ad[0] = 8'h10; dt[0] = 32'hA0A0_0000 + i;
      req[1] = 1; wr[1] = 1; ad[1] = 8'h11; dt[1] = 32'hB0B0_0000 + i;
      run_iter();
    end
    // Drop while busy, then write+read collision.
    clear_stim(); req[0] = 1; ad[0] = 8'h10; lat[0] = 2; dup[0] = 1; run_iter();
    clear_stim(); req[0] = 1; wr[0] = 1; wrrd[0] = 1; ad[0] = 8'h20; dt[0] = 32'h0BAD_F00D; run_iter();
    // Timeout followed by a normal write.
    clear_stim(); req[1] = 1; ad[1] = 8'h07; lat[1] = -1; run_iter();
    clear_stim(); req[1] = 1; wr[1] = 1; ad[1] = 8'h07; dt[1] = 32'h5555_AAAA; run_iter();

    for (int it = 0; it < 25; it++) begin
      clear_stim();
      for (int k = 0; k < 2; k++) begin
        req[k] = 1'($urandom_range(0, 1));
        wr[k]  = 1'($urandom_range(0, 1));
        ad[k]  = AW'($urandom_range(0, 7));
        dt[k]  = $urandom;
        lat[k] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
      end
      if (!req[0] && !req[1]) req[$urandom_range(0, 1)] = 1;
      for (int k = 0; k < 2; k++) begin
        dup[k]  = req[k] && ($urandom_range(0, 3) == 0);
        wrrd[k] = req[k] && wr[k] && ($urandom_range(0, 3) == 0);
      end
      spur = ($urandom_range(0, 2) == 0);
      run_iter();
    end

    // Reset in the middle of a read wait.
    clear_stim();
    @(posedge clk); #1; bus.i_r_en[0] = 1'b1; bus.i_r_addr[AW-1:0] = 8'h02;
    @(posedge clk); #1; bus.i_r_en = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", bus.o_busy, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy",  bus.o_busy, 2'b00);
    chk("mrst_bus",   {bus.o_w_en, bus.o_r_en, bus.o_w_addr, bus.o_r_addr, bus.o_w_value}, '0);
    chk("mrst_flags", {bus.o_r_valid, bus.o_drop, bus.o_timeout}, '0);
    chk("mrst_rval",  bus.o_r_value, '0);
    @(posedge clk); #1 bus.i_r_valid = 1'b1; bus.i_r_value = 32'hCAFE_0001;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("late_rv0", bus.o_r_valid, 2'b00);
    @(posedge clk); #1 bus.i_r_valid = 1'b0;
    @(negedge clk);
    chk("late_rv1", {bus.o_r_valid, bus.o_busy, bus.o_timeout}, '0);
    m_last = 1'b1; m_rval[0] = '0; m_rval[1] = '0;
    clear_stim();
    req[0] = 1; wr[0] = 1; ad[0] = 8'h30; dt[0] = 32'h1111_0000;
    req[1] = 1; wr[1] = 1; ad[1] = 8'h31; dt[1] = 32'h2222_0000;
    run_iter();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
